// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources,
// locking ownership across a multi-byte packet until its last byte has been sent.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_byte,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             UART_BYTE_OUT,
  output logic                   UART_START_SEND,
  input  logic [1:0]             UART_RESPONSE,
  output logic                   hold_timeout,
  output logic [2:0]             dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 start_q, start_d;
  logic [7:0]           byte_q, byte_d;
  logic                 last_q, last_d;
  logic                 timeout_q, timeout_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int step);
    int sum;
    sum = (int'(base) + step) % NUM_REQ;
    return IW'(sum);
  endfunction

  function automatic logic [7:0] byte_of(input logic [IW-1:0] idx,
                                         input logic [8*NUM_REQ-1:0] bytes);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == idx) b = bytes[8*i +: 8];
    end
    return b;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First valid requester at or above the rr pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[wrap_inc(rr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_inc(rr_q, k);
      end
    end
  end

  // Handshake: a requester holds req_valid/req_byte/req_last until it sees a
  // one-cycle req_ack; req_done later pulses once the UART reports the byte sent.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    ack_d     = '0;
    done_d    = '0;
    start_d   = 1'b0;
    byte_d    = byte_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = onehot(pick_idx);
          ack_d   = onehot(pick_idx);
          byte_d  = byte_of(pick_idx, req_byte);
          last_d  = req_last[pick_idx];
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!UART_RESPONSE[1]) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (UART_RESPONSE[0]) begin
          done_d = grant_q;
          if (last_q) begin
            grant_d = '0;
            rr_d    = wrap_inc(owner_q, 1);
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (req_valid[owner_q]) begin
          ack_d   = grant_q;
          byte_d  = byte_of(owner_q, req_byte);
          last_d  = req_last[owner_q];
          cnt_d   = '0;
          state_d = S_ARM;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          rr_d      = wrap_inc(owner_q, 1);
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      start_q   <= start_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ack         = ack_q;
  assign req_done        = done_q;
  assign grant           = grant_q;
  assign UART_BYTE_OUT   = byte_q;
  assign UART_START_SEND = start_q;
  assign hold_timeout    = timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester driver, UART responder model,
// and a monitor that checks every START and done pulse against an expected queue.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int HT   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   grant;
  logic [7:0]        uart_byte;
  logic              uart_start;
  logic [1:0]        uart_resp;
  logic              hold_timeout;
  logic [2:0]        dbg_state;

  logic resp_busy;
  logic resp_sent_model;
  logic resp_sent_man;
  logic uart_auto;
  assign uart_resp = {resp_busy, resp_sent_model | resp_sent_man};

  uart_tx_arbiter #(.NUM_REQ(NREQ), .HOLD_TIMEOUT(HT)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_byte        (req_byte),
    .req_last        (req_last),
    .req_ack         (req_ack),
    .req_done        (req_done),
    .grant           (grant),
    .UART_BYTE_OUT   (uart_byte),
    .UART_START_SEND (uart_start),
    .UART_RESPONSE   (uart_resp),
    .hold_timeout    (hold_timeout),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [8:0]  pend_q [NREQ][$];
  logic [11:0] exp_q[$];
  logic [3:0]  done_exp_q[$];
  int          present_cyc [NREQ];
  int          checks = 0;
  int          failures = 0;
  int          timeouts_seen = 0;
  bit          in_flight = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no event expected one within bound", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int r, input logic [7:0] b, input logic last);
    pend_q[r].push_back({last, b});
  endtask

  task automatic expect_tx(input logic [3:0] g, input logic [7:0] b);
    exp_q.push_back({g, b});
    done_exp_q.push_back(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_exp_q.size() == 0 && grant == '0 &&
          dbg_state == 3'd0 && pend_q[0].size() == 0 && pend_q[1].size() == 0 &&
          pend_q[2].size() == 0 && pend_q[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_event(name);
  endtask

  // Requester driver: presents each queued byte until acked.
  initial begin
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && req_ack[r]) begin
          void'(pend_q[r].pop_front());
          req_valid[r] = 1'b0;
        end
        if (!req_valid[r] && pend_q[r].size() > 0) begin
          req_valid[r]       = 1'b1;
          req_byte[8*r +: 8] = pend_q[r][0][7:0];
          req_last[r]        = pend_q[r][0][8];
          present_cyc[r]     = cyc;
        end
      end
    end
  end

  // UART model: byte-sent pulse 5 cycles after START.
  initial begin
    resp_sent_model = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_start && uart_auto) begin
        repeat (5) @(negedge clk);
        resp_sent_model = 1'b1;
        @(negedge clk);
        resp_sent_model = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [11:0] e;
    logic [3:0]  d;
    forever begin
      @(negedge clk);
      if (hold_timeout) timeouts_seen++;
      if (reset) begin
        in_flight = 1'b0;
      end else begin
        if (uart_start) begin
          check("start_overlap", 32'(in_flight), 32'd0);
          in_flight = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL start_unexpected: got grant=0x%0h byte=0x%0h expected no start",
                     grant, uart_byte);
          end else begin
            e = exp_q.pop_front();
            check("start_grant_byte", 32'({grant, uart_byte}), 32'(e));
          end
        end
        if (req_done != '0) begin
          in_flight = 1'b0;
          if (done_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: got 0x%0h expected none", req_done);
          end else begin
            d = done_exp_q.pop_front();
            check("done_onehot", 32'(req_done), 32'(d));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int  t_ack, t_start, t_done, t_to, bad;
    bit  got;
    reset         = 1'b1;
    resp_busy     = 1'b0;
    resp_sent_man = 1'b0;
    uart_auto     = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_start", 32'(uart_start), 32'd0);
    check("rst_byte", 32'(uart_byte), 32'd0);
    check("rst_timeout", 32'(hold_timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // Single byte with latency measurement
    @(posedge clk);
    issue(2, 8'h41, 1'b1);
    expect_tx(4'b0100, 8'h41);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ack[2]) begin t_ack = cyc; got = 1'b1; break; end
    end
    if (!got) fail_event("t1_ack");
    else check("t1_ack_latency", 32'(t_ack - present_cyc[2]), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_start) begin t_start = cyc; got = 1'b1; break; end
    end
    if (!got) fail_event("t1_start");
    else check("t1_start_latency", 32'(t_start - present_cyc[2]), 32'd3);
    wait_drain(100, "t1_drain");

    // Round robin from pointer 0
    do_reset();
    @(posedge clk);
    issue(0, 8'hA0, 1'b1);
    issue(1, 8'hB1, 1'b1);
    issue(2, 8'hC2, 1'b1);
    issue(3, 8'hD3, 1'b1);
    issue(0, 8'hE0, 1'b1);
    expect_tx(4'b0001, 8'hA0);
    expect_tx(4'b0010, 8'hB1);
    expect_tx(4'b0100, 8'hC2);
    expect_tx(4'b1000, 8'hD3);
    expect_tx(4'b0001, 8'hE0);
    wait_drain(400, "t2_drain");

    // Packet lock: req0 two-byte packet ahead of waiting req1
    do_reset();
    @(posedge clk);
    issue(0, 8'h48, 1'b0);
    issue(0, 8'h49, 1'b1);
    issue(1, 8'h52, 1'b1);
    expect_tx(4'b0001, 8'h48);
    expect_tx(4'b0001, 8'h49);
    expect_tx(4'b0010, 8'h52);
    wait_drain(300, "t3_drain");

    // Transmitter busy holds ARM (rr pointer now 2, only req1 pending)
    @(posedge clk);
    resp_busy = 1'b1;
    issue(1, 8'h5A, 1'b1);
    expect_tx(4'b0010, 8'h5A);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ack[1]) begin got = 1'b1; break; end
    end
    if (!got) fail_event("t4_ack");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg_state != 3'd1 || uart_start) bad++;
    end
    check("t4_busy_arm", 32'(bad), 32'd0);
    resp_busy = 1'b0;
    @(negedge clk);
    check("t4_issue_state", 32'(dbg_state), 32'd2);
    check("t4_no_early_start", 32'(uart_start), 32'd0);
    @(negedge clk);
    check("t4_start_after_busy", 32'(uart_start), 32'd1);
    wait_drain(100, "t4_drain");

    // Hold timeout: req2 silent after non-last byte, req3 waiting
    @(posedge clk);
    issue(2, 8'h77, 1'b0);
    issue(3, 8'h33, 1'b1);
    expect_tx(4'b0100, 8'h77);
    expect_tx(4'b1000, 8'h33);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_done[2]) begin t_done = cyc; got = 1'b1; break; end
    end
    if (!got) fail_event("t5_done");
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hold_timeout) begin t_to = cyc; got = 1'b1; break; end
    end
    if (!got) fail_event("t5_timeout");
    else begin
      check("t5_hold_cycles", 32'(t_to - t_done), 32'd4);
      check("t5_grant_released", 32'(grant), 32'd0);
      check("t5_state_idle", 32'(dbg_state), 32'd0);
    end
    wait_drain(200, "t5_drain");

    // Reset in WAIT: move rr pointer to 3 first
    @(posedge clk);
    issue(2, 8'hC3, 1'b1);
    expect_tx(4'b0100, 8'hC3);
    wait_drain(100, "t6_pre_drain");
    uart_auto = 1'b0;
    @(posedge clk);
    issue(1, 8'h99, 1'b1);
    expect_tx(4'b0010, 8'h99);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_start) begin got = 1'b1; break; end
    end
    if (!got) fail_event("t6_start");
    @(negedge clk);
    check("t6_in_wait", 32'(dbg_state), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    done_exp_q.delete();
    resp_sent_man = 1'b1;
    @(negedge clk);
    resp_sent_man = 1'b0;
    check("t6_state", 32'(dbg_state), 32'd0);
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_byte", 32'(uart_byte), 32'd0);
    check("t6_start", 32'(uart_start), 32'd0);
    check("t6_ack", 32'(req_ack), 32'd0);
    check("t6_done", 32'(req_done), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_done != '0 || grant != '0 || uart_start) bad++;
    end
    check("t6_quiet", 32'(bad), 32'd0);
    uart_auto = 1'b1;
    @(posedge clk);
    issue(1, 8'h11, 1'b1);
    issue(3, 8'h3C, 1'b1);
    expect_tx(4'b0010, 8'h11);
    expect_tx(4'b1000, 8'h3C);
    wait_drain(200, "t6_drain");

    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("end_timeouts", 32'(timeouts_seen), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
